// File: rtl/upa2_limc.sv
// G.726 A2 pole-predictor coefficient update (UPA2) followed by the LIMC limiter.
// Start/done sequencer so one instance can be shared across channels.
//
// state | meaning
// IDLE  | waiting for start; captures inputs on start
// FA    | builds the saturated, sign-adjusted A1 term
// GRAD  | forms the gradient term UGA2
// SUM   | applies leakage and produces unlimited A2T
// LIMIT | clamps A2T into A2P and pulses done
module upa2_limc (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4,
    input  logic        start,
    input  logic [15:0] A1,
    input  logic [15:0] A2,
    input  logic        PK0,
    input  logic        PK1,
    input  logic        PK2,
    input  logic        SIGPK,
    output logic        busy,
    output logic        done,
    output logic [15:0] A2P
);

    typedef enum logic [2:0] {IDLE, FA, GRAD, SUM, LIMIT} state_t;

    state_t      state_q;
    logic [15:0] a1_q, a2_q, a2t_q, a2p_q;
    logic        pk0_q, pk1_q, pk2_q, sigpk_q;
    logic [16:0] fa_q, uga2_q;
    logic        busy_q, done_q;

    logic        pks1, pks2;
    logic [16:0] fa1, fa_d, ugb, uga2_d;
    logic [15:0] ula2, a2t_d, a2p_d;

    // Scan chains are plain gated pass-throughs; silent in functional mode.
    assign scan_out0 = scan_enable & test_mode & scan_in0;
    assign scan_out1 = scan_enable & test_mode & scan_in1;
    assign scan_out2 = scan_enable & test_mode & scan_in2;
    assign scan_out3 = scan_enable & test_mode & scan_in3;
    assign scan_out4 = scan_enable & test_mode & scan_in4;

    always_comb begin
        pks1 = pk0_q ^ pk1_q;
        pks2 = pk0_q ^ pk2_q;
        if (!a1_q[15])
            fa1 = (a1_q <= 16'd8191) ? {a1_q[14:0], 2'b00} : 17'd32764;
        else
            fa1 = (a1_q >= 16'd57345) ? {a1_q[14:0], 2'b00} : 17'd98308;
        fa_d = pks1 ? fa1 : 17'(17'd0 - fa1);

        ugb = (pks2 ? 17'd114688 : 17'd16384) + fa_q;
        if (sigpk_q)
            uga2_d = 17'd0;
        else
            uga2_d = (ugb >> 7) + (ugb[16] ? 17'd126976 : 17'd0);

        // Leakage term: -(A2 >> 7) with sign extension for negative A2
        if (a2_q[15])
            ula2 = 16'(16'd0 - ((a2_q >> 7) + 16'd65024));
        else
            ula2 = 16'(16'd0 - (a2_q >> 7));
        a2t_d = 16'(a2_q + 16'(uga2_q + {1'b0, ula2}));

        if (a2t_q >= 16'd32768 && a2t_q <= 16'd53248)
            a2p_d = 16'd53248;
        else if (a2t_q >= 16'd12288 && a2t_q <= 16'd32767)
            a2p_d = 16'd12288;
        else
            a2p_d = a2t_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a1_q    <= '0;
            a2_q    <= '0;
            pk0_q   <= 1'b0;
            pk1_q   <= 1'b0;
            pk2_q   <= 1'b0;
            sigpk_q <= 1'b0;
            fa_q    <= '0;
            uga2_q  <= '0;
            a2t_q   <= '0;
            a2p_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a1_q    <= A1;
                        a2_q    <= A2;
                        pk0_q   <= PK0;
                        pk1_q   <= PK1;
                        pk2_q   <= PK2;
                        sigpk_q <= SIGPK;
                        busy_q  <= 1'b1;
                        state_q <= FA;
                    end
                end
                FA: begin
                    fa_q    <= fa_d;
                    state_q <= GRAD;
                end
                GRAD: begin
                    uga2_q  <= uga2_d;
                    state_q <= SUM;
                end
                SUM: begin
                    a2t_q   <= a2t_d;
                    state_q <= LIMIT;
                end
                LIMIT: begin
                    a2p_q   <= a2p_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign A2P  = a2p_q;

endmodule

// File: tb/tb_upa2_limc.sv
// Directed and randomized checks of upa2_limc against an integer model of the
// G.726 UPA2/LIMC rules, including latency, start-while-busy and reset abort.
module tb_upa2_limc;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_enable, test_mode;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
    logic        start;
    logic [15:0] A1, A2;
    logic        PK0, PK1, PK2, SIGPK;
    logic        busy, done;
    logic [15:0] A2P;

    int n_cmp = 0;
    int n_err = 0;
    int held;

    always #5 clk = ~clk;

    upa2_limc dut (
        .clk(clk), .reset(reset),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4),
        .start(start), .A1(A1), .A2(A2),
        .PK0(PK0), .PK1(PK1), .PK2(PK2), .SIGPK(SIGPK),
        .busy(busy), .done(done), .A2P(A2P)
    );

    function automatic int model(int a1, int a2, int pk0, int pk1, int pk2, int sigpk);
        int pks1, pks2, fa1, fa, ugb, uga2, ula2, ua2, a2t;
        pks1 = pk0 ^ pk1;
        pks2 = pk0 ^ pk2;
        if (a1 < 32768) fa1 = (a1 <= 8191) ? a1 * 4 : 32764;
        else            fa1 = (a1 >= 57345) ? (a1 * 4) % 131072 : 98308;
        fa = pks1 ? fa1 : (131072 - fa1) % 131072;
        ugb = ((pks2 ? 114688 : 16384) + fa) % 131072;
        uga2 = sigpk ? 0 : ugb / 128 + ((ugb >= 65536) ? 126976 : 0);
        if (a2 >= 32768) ula2 = (65536 - (a2 / 128 + 65024)) % 65536;
        else             ula2 = (65536 - a2 / 128) % 65536;
        ua2 = (uga2 + ula2) % 65536;
        a2t = (a2 + ua2) % 65536;
        if (a2t >= 32768 && a2t <= 53248) return 53248;
        if (a2t >= 12288 && a2t <= 32767) return 12288;
        return a2t;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a start pulse now (caller is just after a negedge).
    task automatic issue(int a1, int a2, int pk0, int pk1, int pk2, int sg);
        A1 = 16'(a1); A2 = 16'(a2);
        PK0 = 1'(pk0); PK1 = 1'(pk1); PK2 = 1'(pk2); SIGPK = 1'(sg);
        start = 1'b1;
    endtask

    // Walks the four busy cycles and checks the done cycle; ends in the done cycle.
    task automatic finish_op(string tag, int exp);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                A1 = 16'($urandom); A2 = 16'($urandom);
                {PK0, PK1, PK2, SIGPK} = 4'($urandom);
            end
            chk({tag, "_busy"}, int'(busy), 1);
            chk({tag, "_nodone"}, int'(done), 0);
            chk({tag, "_hold"}, int'(A2P), held);
        end
        @(negedge clk);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_a2p"}, int'(A2P), exp);
        held = exp;
    endtask

    task automatic run(string tag, int a1, int a2, int pk0, int pk1, int pk2, int sg);
        @(negedge clk);
        issue(a1, a2, pk0, pk1, pk2, sg);
        finish_op(tag, model(a1, a2, pk0, pk1, pk2, sg));
    endtask

    initial begin
        int a1, a2, pk;
        reset = 1'b1; start = 1'b0;
        A1 = '0; A2 = '0; {PK0, PK1, PK2, SIGPK} = '0;
        {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b10110;
        scan_enable = 1'b0; test_mode = 1'b0;
        held = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_a2p", int'(A2P), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("scan_quiet", int'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 0);

        // Directed vectors with hand-derived results
        chk("model_base", model(0, 0, 0, 0, 0, 0), 128);
        run("base", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("done_drop", int'(done), 0);
        run("sigpk", 0, 0, 0, 0, 0, 1);
        chk("sigpk_val", held, 0);
        run("clamp_hi", 0, 12288, 0, 0, 0, 0);
        chk("clamp_hi_val", held, 12288);
        run("clamp_lo", 0, 53248, 1, 1, 0, 0);
        chk("clamp_lo_val", held, 53248);
        run("fa_sat", 16384, 0, 1, 0, 1, 0);
        chk("fa_sat_val", held, 383);

        // A1 saturation boundaries
        run("a1_8191", 8191, 1000, 1, 0, 0, 0);
        run("a1_8192", 8192, 1000, 1, 0, 0, 0);
        run("a1_57345", 57345, 60000, 0, 0, 1, 0);
        run("a1_57344", 57344, 60000, 0, 1, 1, 0);

        // Second start two cycles in is ignored
        @(negedge clk);
        issue(100, 2000, 0, 1, 0, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(5000, 40000, 1, 1, 1, 0);
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", int'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        chk("ign_done", int'(done), 1);
        chk("ign_a2p", int'(A2P), model(100, 2000, 0, 1, 0, 0));
        held = model(100, 2000, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ign_quiet", int'(done | busy), 0);
        end

        // Start in the done cycle is accepted
        run("b2b_a", 3000, 20000, 0, 1, 1, 0);
        issue(60000, 45000, 1, 0, 0, 0);
        finish_op("b2b_b", model(60000, 45000, 1, 0, 0, 0));

        // Reset during SUM aborts with no done
        @(negedge clk);
        issue(700, 9000, 1, 0, 1, 0);
        repeat (3) @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_a2p", int'(A2P), 0);
        @(negedge clk);
        reset = 1'b0;
        held = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_nodone", int'(done), 0);
        end

        // Randomized vectors against the model
        for (int i = 0; i < 24; i++) begin
            a1 = int'($urandom_range(0, 65535));
            a2 = int'($urandom_range(0, 65535));
            pk = int'($urandom_range(0, 15));
            run("rand", a1, a2, pk & 1, (pk >> 1) & 1, (pk >> 2) & 1, (pk >> 3) & 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
